// File: rtl/mlp_infer_seq.sv
// Inference sequencer and MAC datapath for a 784-32-10 quantised MLP.
// Row-serial fetch: one input row per cycle, all neurons of a layer accumulate in parallel.

module mlp_mac_lane (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [7:0]  i_bias,
  input  logic [8:0]  i_a,
  input  logic [7:0]  i_w,
  output logic [31:0] o_acc,
  output logic [31:0] o_nxt
);
  logic [16:0] w_a;
  logic [16:0] w_w;
  logic [16:0] w_prod;

  // Operands widened to 17 bits so the truncated product is the exact signed result.
  assign w_a    = {{8{i_a[8]}}, i_a};
  assign w_w    = {{9{i_w[7]}}, i_w};
  assign w_prod = 17'($signed(w_a) * $signed(w_w));
  assign o_nxt  = o_acc + {{15{w_prod[16]}}, w_prod};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      o_acc <= '0;
    else if (i_load) o_acc <= {{24{i_bias[7]}}, i_bias};
    else if (i_en)   o_acc <= o_nxt;
  end
endmodule

module mlp_infer_seq #(
  parameter int SHIFT1 = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [9:0]      o_pixel_addr,
  input  logic [7:0]      i_pixel_data,
  output logic [1:0]      o_layer_sel,
  output logic [9:0]      o_row_idx,
  input  logic [31:0][7:0] i_w1_in,
  input  logic [31:0][7:0] i_b1_in,
  input  logic [9:0][7:0]  i_w2_in,
  input  logic [9:0][7:0]  i_b2_in,
  output logic [9:0][31:0] o_logits,
  output logic [3:0]      o_pred
);
  localparam int NUM_HID = 32;
  localparam int NUM_OUT = 10;
  localparam logic [9:0] L1_LAST = 10'd783;
  localparam logic [9:0] L2_LAST = 10'd31;
  localparam logic [9:0] AM_LAST = 10'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_L1_INIT, S_L1_MAC, S_L1_ACT, S_L2_INIT, S_L2_MAC, S_ARGMAX, S_DONE
  } state_t;

  state_t r_state, w_nxt_state;
  logic [9:0] r_k, w_nxt_k;

  logic [NUM_HID-1:0][31:0] w_acc1;
  logic [NUM_HID-1:0][31:0] w_nxt1;
  logic [NUM_OUT-1:0][31:0] w_acc2;
  logic [NUM_OUT-1:0][31:0] w_nxt2;
  logic [NUM_HID-1:0][7:0]  r_h;
  logic [NUM_HID-1:0][7:0]  w_h;
  logic [7:0]  w_hk;
  logic [31:0] w_cand;
  logic [31:0] r_best_val;
  logic [3:0]  r_best_idx;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_k     = r_k;
    case (r_state)
      S_IDLE:    if (i_start) begin w_nxt_state = S_L1_INIT; w_nxt_k = '0; end
      S_L1_INIT: begin w_nxt_state = S_L1_MAC; w_nxt_k = '0; end
      S_L1_MAC:  if (r_k == L1_LAST) begin w_nxt_state = S_L1_ACT; w_nxt_k = '0; end
                 else w_nxt_k = r_k + 10'd1;
      S_L1_ACT:  w_nxt_state = S_L2_INIT;
      S_L2_INIT: begin w_nxt_state = S_L2_MAC; w_nxt_k = '0; end
      S_L2_MAC:  if (r_k == L2_LAST) begin w_nxt_state = S_ARGMAX; w_nxt_k = '0; end
                 else w_nxt_k = r_k + 10'd1;
      S_ARGMAX:  if (r_k == AM_LAST) begin w_nxt_state = S_DONE; w_nxt_k = '0; end
                 else w_nxt_k = r_k + 10'd1;
      S_DONE:    w_nxt_state = S_IDLE;
      default:   begin w_nxt_state = S_IDLE; w_nxt_k = '0; end
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_HID; g++) begin : g_l1
      logic [31:0] w_sh;
      mlp_mac_lane u_lane (
        .i_clk (i_clk), .i_rst (i_rst),
        .i_load(r_state == S_L1_INIT), .i_en(r_state == S_L1_MAC),
        .i_bias(i_b1_in[g]), .i_a({1'b0, i_pixel_data}), .i_w(i_w1_in[g]),
        .o_acc (w_acc1[g]), .o_nxt(w_nxt1[g])
      );
      // ReLU then requantise: negative -> 0, otherwise shift and saturate at 127.
      assign w_sh   = $signed(w_acc1[g]) >>> SHIFT1;
      assign w_h[g] = w_acc1[g][31] ? 8'd0 :
                      ($signed(w_sh) > 32'sd127) ? 8'd127 : w_sh[7:0];
    end
    for (g = 0; g < NUM_OUT; g++) begin : g_l2
      mlp_mac_lane u_lane (
        .i_clk (i_clk), .i_rst (i_rst),
        .i_load(r_state == S_L2_INIT), .i_en(r_state == S_L2_MAC),
        .i_bias(i_b2_in[g]), .i_a({1'b0, w_hk}), .i_w(i_w2_in[g]),
        .o_acc (w_acc2[g]), .o_nxt(w_nxt2[g])
      );
    end
  endgenerate

  assign w_hk   = r_h[r_k[4:0]];
  assign w_cand = o_logits[r_k[3:0]];

  // Output registers are loaded from next-state values so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_layer_sel  <= '0;
      o_row_idx    <= '0;
      o_pixel_addr <= '0;
      r_h          <= '0;
      o_logits     <= '0;
      r_best_val   <= '0;
      r_best_idx   <= '0;
      o_pred       <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_k          <= w_nxt_k;
      o_busy       <= (w_nxt_state != S_IDLE);
      o_done       <= (w_nxt_state == S_DONE);
      o_layer_sel  <= (w_nxt_state == S_L1_INIT || w_nxt_state == S_L1_MAC) ? 2'd1 :
                      (w_nxt_state == S_L2_INIT || w_nxt_state == S_L2_MAC) ? 2'd2 : 2'd0;
      o_row_idx    <= (w_nxt_state == S_L1_MAC || w_nxt_state == S_L2_MAC) ? w_nxt_k : 10'd0;
      o_pixel_addr <= (w_nxt_state == S_L1_MAC) ? w_nxt_k : 10'd0;
      if (r_state == S_L1_ACT) r_h <= w_h;
      if (r_state == S_L2_MAC && r_k == L2_LAST) o_logits <= w_nxt2;
      // Strictly-greater replacement keeps the lowest index on ties.
      if (r_state == S_ARGMAX &&
          (r_k == 10'd0 || $signed(w_cand) > $signed(r_best_val))) begin
        r_best_val <= w_cand;
        r_best_idx <= r_k[3:0];
      end
      if (r_state == S_DONE) o_pred <= r_best_idx;
    end
  end
endmodule

// File: tb/tb_mlp_infer_seq.sv
// Bench for mlp_infer_seq: two instances (SHIFT1=0 and 8) run in lockstep against a reference model.

module tb_mlp_infer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic busy0, done0, busy8, done8;
  logic [9:0] pa0, ra0, pa8, ra8;
  logic [1:0] ls0, ls8;
  logic [3:0] pr0, pr8;
  logic [9:0][31:0] lg0, lg8;
  logic [7:0] pixel;
  logic [31:0][7:0] w1, b1;
  logic [9:0][7:0] w2, b2;

  logic [7:0]        pix_m [784];
  logic signed [7:0] w1_m  [784][32];
  logic signed [7:0] w2_m  [32][10];
  logic signed [7:0] b1_v  [32];
  logic signed [7:0] b2_v  [10];

  mlp_infer_seq #(.SHIFT1(0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .o_busy(busy0), .o_done(done0),
    .o_pixel_addr(pa0), .i_pixel_data(pixel), .o_layer_sel(ls0), .o_row_idx(ra0),
    .i_w1_in(w1), .i_b1_in(b1), .i_w2_in(w2), .i_b2_in(b2), .o_logits(lg0), .o_pred(pr0));
  mlp_infer_seq #(.SHIFT1(8)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .o_busy(busy8), .o_done(done8),
    .o_pixel_addr(pa8), .i_pixel_data(pixel), .o_layer_sel(ls8), .o_row_idx(ra8),
    .i_w1_in(w1), .i_b1_in(b1), .i_w2_in(w2), .i_b2_in(b2), .o_logits(lg8), .o_pred(pr8));

  // Combinational pixel buffer and weight memory, addressed by the SHIFT1=0 instance.
  always_comb begin
    pixel = pix_m[pa0];
    for (int j = 0; j < 32; j++) begin
      w1[j] = w1_m[ra0][j];
      b1[j] = b1_v[j];
    end
    for (int i = 0; i < 10; i++) begin
      w2[i] = w2_m[ra0[4:0]][i];
      b2[i] = b2_v[i];
    end
  end

  typedef struct packed {
    logic [9:0][31:0] lg;
    logic [3:0]       pr;
  } res_t;

  res_t q0[$];
  res_t q8[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic res_t model(input int sh);
    res_t r;
    int h[32];
    longint a, bv;
    r = '0;
    bv = 0;
    for (int j = 0; j < 32; j++) begin
      a = longint'(b1_v[j]);
      for (int k = 0; k < 784; k++) a += longint'(pix_m[k]) * longint'(w1_m[k][j]);
      if (a < 0) h[j] = 0;
      else begin
        a = a >>> sh;
        h[j] = (a > 127) ? 127 : int'(a);
      end
    end
    for (int i = 0; i < 10; i++) begin
      a = longint'(b2_v[i]);
      for (int k = 0; k < 32; k++) a += longint'(h[k]) * longint'(w2_m[k][i]);
      r.lg[i] = a[31:0];
      if (i == 0 || a > bv) begin
        bv = a;
        r.pr = i[3:0];
      end
    end
    return r;
  endfunction

  task automatic cfg(input int p, input int w1v, input int b1v, input int w2v, input int b2v);
    for (int k = 0; k < 784; k++) begin
      pix_m[k] = 8'(p);
      for (int j = 0; j < 32; j++) w1_m[k][j] = 8'(w1v);
    end
    for (int j = 0; j < 32; j++) begin
      b1_v[j] = 8'(b1v);
      for (int i = 0; i < 10; i++) w2_m[j][i] = 8'(w2v);
    end
    for (int i = 0; i < 10; i++) b2_v[i] = 8'(b2v);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run();
    int n;
    q0.push_back(model(0));
    q8.push_back(model(8));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("c1_busy", 32'(busy0), 32'd1);
    chk("c1_lsel_row", {20'd0, ls0, ra0}, {20'd0, 2'd1, 10'd0});
    while (!done0 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 5)   chk("l1_pix_addr", {20'd0, ls0, pa0}, {20'd0, 2'd1, 10'd3});
      if (n == 786) chk("act_lsel", 32'(ls0), 32'd0);
      if (n == 790) chk("l2_lsel_row", {20'd0, ls0, ra0}, {20'd0, 2'd2, 10'd2});
    end
    chk("done_latency", 32'(n), 32'd830);
    chk("done_busy", 32'(busy0 & done8), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(busy0 | busy8), 32'd0);
  endtask

  // Scoreboard: when done pulses, results are compared the following cycle (pred valid).
  initial begin
    res_t e0, e8;
    forever begin
      @(negedge clk);
      if (done0) begin
        @(negedge clk);
        chk("done_one_cycle", 32'(done0), 32'd0);
        chk("sb_pending", 32'(q0.size() > 0 && q8.size() > 0), 32'd1);
        if (q0.size() > 0 && q8.size() > 0) begin
          e0 = q0.pop_front();
          e8 = q8.pop_front();
          for (int i = 0; i < 10; i++) begin
            chk($sformatf("logit_s0[%0d]", i), lg0[i], e0.lg[i]);
            chk($sformatf("logit_s8[%0d]", i), lg8[i], e8.lg[i]);
          end
          chk("pred_s0", 32'(pr0), 32'(e0.pr));
          chk("pred_s8", 32'(pr8), 32'(e8.pr));
        end
      end
    end
  end

  initial begin
    int n;
    cfg(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ctl", {4'd0, busy0, done0, ls0, ra0, pa0, pr0}, 32'd0);
    end
    chk("rst_logits", 32'(|lg0 | |lg8 | |pr8), 32'd0);

    // All ones, SHIFT1=0 saturates h at 127: logits 4064, tie -> pred 0.
    cfg(1, 1, 0, 1, 0);
    run();
    // Negative layer 1 zeroes h; logits are just the biases.
    cfg(200, -1, 0, 1, 0);
    for (int i = 0; i < 10; i++) b2_v[i] = 8'(i);
    run();
    cfg(255, 127, 0, 1, 0);
    for (int k = 0; k < 32; k++) w2_m[k][4] = 8'sd2;
    run();
    // Tie between classes 3 and 7 resolves to 3.
    cfg(200, -1, 0, 1, 0);
    b2_v[3] = 8'sd5;
    b2_v[7] = 8'sd5;
    run();
    // Random image and weights; small w1 keeps h away from the clamp.
    for (int k = 0; k < 784; k++) begin
      pix_m[k] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 32; j++) w1_m[k][j] = 8'(int'($urandom_range(0, 8)) - 4);
    end
    for (int j = 0; j < 32; j++) begin
      b1_v[j] = 8'($urandom);
      for (int i = 0; i < 10; i++) w2_m[j][i] = 8'($urandom);
    end
    for (int i = 0; i < 10; i++) b2_v[i] = 8'($urandom);
    run();

    // Start during busy is ignored; reset mid-run clears everything.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 300) start = 1'b1;
      if (n == 301) begin
        start = 1'b0;
        chk("ignored_start", {20'd0, ls0, pa0}, {20'd0, 2'd1, 10'd299});
      end
    end
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {4'd0, busy0, done0, ls0, ra0, pa0, pr0}, 32'd0);
    chk("abort_logits", 32'(|lg0 | |lg8 | |pr8 | busy8), 32'd0);
    repeat (2) @(negedge clk);
    q0.delete();
    q8.delete();
    rst_n = 1'b1;
    @(negedge clk);
    cfg(1, 1, 0, 1, 0);
    run();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
